// File: rtl/cp0_wbuf_pkg.sv
// cp0_wbuf_pkg: shared CP0 write-request type and write-buffer defaults
package cp0_wbuf_pkg;
    localparam int CP0_WBUF_DEPTH = 4;
    localparam int CP0_COMMIT_WIDTH = 2;
    typedef logic [$clog2(CP0_WBUF_DEPTH)-1:0] cp0_wbuf_ptr_t;
    typedef struct packed {
        logic        we;
        logic [4:0]  waddr;
        logic [2:0]  wsel;
        logic [31:0] wdata;
    } cp0_req_t;
endpackage

// File: rtl/cp0_wbuf_fwd.sv
// cp0_wbuf_fwd: youngest-match forwarding search over a circular pending window
module cp0_wbuf_fwd
    import cp0_wbuf_pkg::*;
#(
    parameter int DEPTH = CP0_WBUF_DEPTH,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  cp0_req_t [DEPTH-1:0] entries,
    input  logic [PTR_W-1:0]     head,
    input  logic [PTR_W:0]       count,
    input  logic [4:0]           raddr,
    input  logic [2:0]           rsel,
    output logic                 hit,
    output logic [31:0]          data
);
    // scan oldest to youngest so the last match left standing is the youngest
    always_comb begin
        hit = 1'b0;
        data = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if ((PTR_W+1)'(k) < count && entries[head + PTR_W'(k)].waddr == raddr && entries[head + PTR_W'(k)].wsel == rsel) begin
                hit = 1'b1;
                data = entries[head + PTR_W'(k)].wdata;
            end
        end
    end
endmodule

// File: rtl/cp0_wbuf.sv
// cp0_wbuf: speculative in-order CP0 write buffer with multi-lane commit and forwarding
module cp0_wbuf
    import cp0_wbuf_pkg::*;
#(
    parameter int DEPTH = CP0_WBUF_DEPTH,
    parameter int COMMIT_WIDTH = CP0_COMMIT_WIDTH,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        flush,
    input  cp0_req_t                    wreq,
    output logic                        wreq_ready,
    input  logic [COMMIT_WIDTH-1:0]     commit,
    output cp0_req_t [COMMIT_WIDTH-1:0] wcommit,
    input  logic [4:0]                  raddr,
    input  logic [2:0]                  rsel,
    output logic                        fwd_hit,
    output logic [31:0]                 fwd_data,
    output logic [PTR_W:0]              pending,
    output logic                        proto_err
);
    localparam logic [PTR_W:0] ONE = 1;
    cp0_req_t [DEPTH-1:0] mem;
    logic [PTR_W-1:0] head, tail, fhead;
    logic [PTR_W:0] n, fcnt;
    logic run, bad, enq, hit;
    logic [31:0] data;
    assign wreq_ready = pending != (PTR_W+1)'(DEPTH);
    assign enq = wreq.we && wreq_ready && !flush;
    assign fhead = head + n[PTR_W-1:0];
    assign fcnt = pending - n;
    assign fwd_hit = hit && !rst;
    assign fwd_data = rst ? '0 : data;
    // retire count: leading ones of commit clamped to occupancy; flag lanes beyond occupancy
    always_comb begin
        n = '0;
        run = 1'b1;
        bad = 1'b0;
        for (int i = 0; i < COMMIT_WIDTH; i++) begin
            run = run & commit[i];
            n = (run && (PTR_W+1)'(i) < pending) ? n + ONE : n;
            bad = bad | (commit[i] && (PTR_W+1)'(i) >= pending);
        end
    end
    // lanes expose the oldest entries in order; only the first n are marked as writes
    always_comb begin
        for (int i = 0; i < COMMIT_WIDTH; i++) begin
            wcommit[i] = mem[head + PTR_W'(i)];
            wcommit[i].we = !rst && (PTR_W+1)'(i) < n;
        end
    end
    // payload storage at the tail
    always_ff @(posedge clk) begin
        if (enq) mem[tail] <= wreq;
    end
    // pointers, occupancy and sticky protocol error
    always_ff @(posedge clk) begin
        if (rst) begin
            head <= '0;
            tail <= '0;
            pending <= '0;
            proto_err <= 1'b0;
        end else begin
            proto_err <= proto_err | bad | (wreq.we && !wreq_ready);
            head <= flush ? '0 : fhead;
            tail <= flush ? '0 : tail + PTR_W'(enq);
            pending <= flush ? '0 : pending + (PTR_W+1)'(enq) - n;
        end
    end
    cp0_wbuf_fwd #(.DEPTH(DEPTH)) u_fwd (
        .entries(mem),
        .head(fhead),
        .count(fcnt),
        .raddr(raddr),
        .rsel(rsel),
        .hit(hit),
        .data(data)
    );
endmodule

// File: tb/tb_cp0_wbuf.sv
// tb_cp0_wbuf: table-driven, directed and randomized checks against a queue model
module tb_cp0_wbuf;
    import cp0_wbuf_pkg::*;
    localparam int DEPTH = 4;
    localparam int CW = 2;
    logic clk, rst, flush, wreq_ready, fwd_hit, proto_err;
    cp0_req_t wreq;
    logic [CW-1:0] commit;
    cp0_req_t [CW-1:0] wcommit;
    logic [4:0] raddr;
    logic [2:0] rsel;
    logic [31:0] fwd_data;
    logic [2:0] pending;
    int checks = 0, errors = 0;
    typedef struct {
        logic [4:0]  a;
        logic [2:0]  s;
        logic [31:0] d;
    } ent_t;
    ent_t q[$];
    bit merr;
    logic [31:0] o_pend, o_fd, o_d0, o_d1;
    logic o_ready, o_err, o_hit;
    logic [1:0] o_we;
    typedef struct {
        bit          pre_rst;
        logic        fl;
        logic        w;
        logic [4:0]  a;
        logic [2:0]  s;
        logic [31:0] d;
        logic [1:0]  c;
        logic [4:0]  ra;
        logic [2:0]  rs;
        logic [31:0] e_pend;
        logic        e_ready;
        logic        e_err;
        logic        e_hit;
        logic [31:0] e_fd;
        logic [1:0]  e_we;
        logic [31:0] e_d0;
        logic [31:0] e_d1;
    } vec_t;
    vec_t tv[24];

    cp0_wbuf #(.DEPTH(DEPTH), .COMMIT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst), .flush(flush), .wreq(wreq), .wreq_ready(wreq_ready),
        .commit(commit), .wcommit(wcommit), .raddr(raddr), .rsel(rsel),
        .fwd_hit(fwd_hit), .fwd_data(fwd_data), .pending(pending), .proto_err(proto_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cycle(input logic r, input logic fl, input logic w, input logic [4:0] a, input logic [2:0] s,
                         input logic [31:0] d, input logic [1:0] c, input logic [4:0] ra, input logic [2:0] rs);
        int lead, n;
        bit run, hit, bad, full;
        logic [31:0] fd;
        rst = r;
        flush = fl;
        wreq = '{we: w, waddr: a, wsel: s, wdata: d};
        commit = c;
        raddr = ra;
        rsel = rs;
        @(negedge clk);
        lead = 0;
        run = 1;
        for (int i = 0; i < CW; i++) begin
            run = run && c[i];
            lead += int'(run);
        end
        n = lead < q.size() ? lead : q.size();
        hit = 0;
        fd = 0;
        for (int k = q.size() - 1; k >= n; k--)
            if (!hit && q[k].a == ra && q[k].s == rs) begin
                hit = 1;
                fd = q[k].d;
            end
        if (r) begin
            hit = 0;
            fd = 0;
        end
        full = q.size() == DEPTH;
        chk("pending", 32'(pending), q.size());
        chk("wreq_ready", 32'(wreq_ready), 32'(!full));
        chk("proto_err", 32'(proto_err), 32'(merr));
        chk("fwd_hit", 32'(fwd_hit), 32'(hit));
        chk("fwd_data", fwd_data, fd);
        for (int i = 0; i < CW; i++) begin
            chk("lane_we", 32'(wcommit[i].we), 32'(!r && i < n));
            if (!r && i < n) begin
                chk("lane_data", wcommit[i].wdata, q[i].d);
                chk("lane_addr", {24'(wcommit[i].waddr), 8'(wcommit[i].wsel)}, {24'(q[i].a), 8'(q[i].s)});
            end
        end
        o_pend = 32'(pending);
        o_ready = wreq_ready;
        o_err = proto_err;
        o_hit = fwd_hit;
        o_fd = fwd_data;
        o_we = {wcommit[1].we, wcommit[0].we};
        o_d0 = wcommit[0].wdata;
        o_d1 = wcommit[1].wdata;
        bad = 0;
        for (int i = 0; i < CW; i++) if (c[i] && i >= q.size()) bad = 1;
        @(posedge clk);
        if (r) begin
            q.delete();
            merr = 0;
        end else begin
            merr = merr || bad || (w && full);
            repeat (n) void'(q.pop_front());
            if (fl) q.delete();
            else if (w && !full) q.push_back('{a, s, d});
        end
        #1;
    endtask

    initial begin
        logic [31:0] dd;
        tv[0]  = '{1, 0, 1, 12, 0, 32'hFF01, 0, 12, 0, 0, 1, 0, 0, 0, 0, 0, 0};
        tv[1]  = '{0, 0, 0, 0, 0, 0, 1, 12, 0, 1, 1, 0, 0, 0, 1, 32'hFF01, 0};
        tv[2]  = '{0, 0, 0, 0, 0, 0, 0, 12, 0, 0, 1, 0, 0, 0, 0, 0, 0};
        tv[3]  = '{0, 0, 1, 11, 0, 32'h11, 0, 13, 0, 0, 1, 0, 0, 0, 0, 0, 0};
        tv[4]  = '{0, 0, 1, 12, 0, 32'h12, 0, 13, 0, 1, 1, 0, 0, 0, 0, 0, 0};
        tv[5]  = '{0, 0, 1, 13, 0, 32'h13, 0, 13, 0, 2, 1, 0, 0, 0, 0, 0, 0};
        tv[6]  = '{0, 0, 1, 14, 0, 32'h14, 0, 13, 0, 3, 1, 0, 1, 32'h13, 0, 0, 0};
        tv[7]  = '{0, 0, 1, 15, 0, 32'h15, 0, 13, 0, 4, 0, 0, 1, 32'h13, 0, 0, 0};
        tv[8]  = '{0, 0, 0, 0, 0, 0, 3, 11, 0, 4, 0, 1, 0, 0, 3, 32'h11, 32'h12};
        tv[9]  = '{0, 0, 0, 0, 0, 0, 0, 13, 0, 2, 1, 1, 1, 32'h13, 0, 0, 0};
        tv[10] = '{1, 0, 1, 12, 0, 32'hA, 0, 12, 0, 0, 1, 0, 0, 0, 0, 0, 0};
        tv[11] = '{0, 0, 1, 12, 0, 32'hB, 0, 12, 0, 1, 1, 0, 1, 32'hA, 0, 0, 0};
        tv[12] = '{0, 0, 0, 0, 0, 0, 1, 12, 0, 2, 1, 0, 1, 32'hB, 1, 32'hA, 0};
        tv[13] = '{0, 0, 0, 0, 0, 0, 1, 12, 0, 1, 1, 0, 0, 0, 1, 32'hB, 0};
        tv[14] = '{0, 0, 0, 0, 0, 0, 0, 12, 0, 0, 1, 0, 0, 0, 0, 0, 0};
        tv[15] = '{0, 0, 1, 1, 0, 32'h1, 0, 9, 0, 0, 1, 0, 0, 0, 0, 0, 0};
        tv[16] = '{0, 0, 1, 2, 0, 32'h2, 0, 9, 0, 1, 1, 0, 0, 0, 0, 0, 0};
        tv[17] = '{0, 0, 1, 3, 0, 32'h3, 0, 9, 0, 2, 1, 0, 0, 0, 0, 0, 0};
        tv[18] = '{0, 1, 1, 9, 0, 32'h99, 1, 9, 0, 3, 1, 0, 0, 0, 1, 32'h1, 0};
        tv[19] = '{0, 0, 0, 0, 0, 0, 0, 9, 0, 0, 1, 0, 0, 0, 0, 0, 0};
        tv[20] = '{0, 0, 1, 4, 0, 32'h4, 0, 4, 0, 0, 1, 0, 0, 0, 0, 0, 0};
        tv[21] = '{0, 0, 1, 5, 0, 32'h5, 0, 4, 0, 1, 1, 0, 1, 32'h4, 0, 0, 0};
        tv[22] = '{0, 0, 0, 0, 0, 0, 2, 4, 0, 2, 1, 0, 1, 32'h4, 0, 0, 0};
        tv[23] = '{0, 0, 0, 0, 0, 0, 0, 4, 0, 2, 1, 0, 1, 32'h4, 0, 0, 0};
        rst = 1;
        flush = 0;
        wreq = '0;
        commit = '0;
        raddr = '0;
        rsel = '0;
        merr = 0;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 24; i++) begin
            if (tv[i].pre_rst) cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);
            cycle(0, tv[i].fl, tv[i].w, tv[i].a, tv[i].s, tv[i].d, tv[i].c, tv[i].ra, tv[i].rs);
            chk($sformatf("tv%0d_pending", i), o_pend, tv[i].e_pend);
            chk($sformatf("tv%0d_ready", i), 32'(o_ready), 32'(tv[i].e_ready));
            chk($sformatf("tv%0d_err", i), 32'(o_err), 32'(tv[i].e_err));
            chk($sformatf("tv%0d_hit", i), 32'(o_hit), 32'(tv[i].e_hit));
            chk($sformatf("tv%0d_fdata", i), o_fd, tv[i].e_fd);
            chk($sformatf("tv%0d_we", i), 32'(o_we), 32'(tv[i].e_we));
            if (tv[i].e_we[0]) chk($sformatf("tv%0d_d0", i), o_d0, tv[i].e_d0);
            if (tv[i].e_we[1]) chk($sformatf("tv%0d_d1", i), o_d1, tv[i].e_d1);
        end
        cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 6; k++) begin
            dd = $urandom;
            cycle(0, 0, 1, 5'(16 + k), 3'(k), dd, 0, 0, 0);
            cycle(0, 0, 0, 0, 0, 0, 1, 0, 0);
            chk("wrap_we", 32'(o_we), 1);
            chk("wrap_data", o_d0, dd);
        end
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("wrap_empty", o_pend, 0);
        for (int t = 0; t < 800; t++)
            cycle($urandom_range(0, 39) == 0, $urandom_range(0, 19) == 0, $urandom_range(0, 2) != 0,
                  5'($urandom_range(0, 3)), 3'($urandom_range(0, 1)), $urandom,
                  2'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 3'($urandom_range(0, 1)));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
